// File: rtl/wired_lz_decode.sv
// Purpose: turns a leading-zero count back into the one-hot leading-one position and a thermometer mask below it.
// Latency: 2 cycles (S1 holds the request, S2 holds the decoded result), 1 result per cycle at full throughput.
// Backpressure: valid/ready on both sides; ready_o depends combinationally on ready_i so a full pipe still streams.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   valid_i/ready_o     request handshake; cnt_i = leading-zero count, zero_i = all-zero vector
//   valid_o/ready_i     result handshake; onehot_o, mask_o, err_o (cnt_i >= WIDTH while zero_i = 0)
module wired_lz_decode #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [CW-1:0]    cnt_i,
  input  logic             zero_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  // One extra bit so WIDTH itself is representable for the range compare.
  localparam logic [CW:0]      WIDTH_L  = (CW+1)'(WIDTH);

  // Stage 1: captured request
  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_cnt_q,   s1_cnt_d;
  logic          s1_zero_q,  s1_zero_d;

  // Stage 2: decoded result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] onehot_q,   onehot_d;
  logic [WIDTH-1:0] mask_q,     mask_d;
  logic             err_q,      err_d;

  // Handshake / advance
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  // Decoder working on the S1 contents
  logic             cnt_oor;
  logic [WIDTH-1:0] dec_onehot;
  logic [WIDTH-1:0] dec_mask;
  logic             dec_err;

  always_comb begin
    s2_adv  = ~s2_valid_q | ready_i;
    s1_adv  = s1_valid_q & s2_adv;
    ready_o = ~s1_valid_q | s2_adv;
    in_fire = valid_i & ready_o;
  end

  // Shifting a single MSB right by the count lands on bit WIDTH-1-cnt; shifting
  // all-ones right by the same amount leaves ones from that bit down to bit 0.
  // Counts at or above WIDTH only exist for non-power-of-2 widths.
  always_comb begin
    cnt_oor    = ({1'b0, s1_cnt_q} >= WIDTH_L);
    dec_onehot = '0;
    dec_mask   = '0;
    dec_err    = 1'b0;
    if (!s1_zero_q) begin
      if (cnt_oor) begin
        dec_err = 1'b1;
      end else begin
        dec_onehot = MSB_ONLY >> s1_cnt_q;
        dec_mask   = ALL_ONES >> s1_cnt_q;
      end
    end
  end

  always_comb begin
    // S1 accepts whenever it has room (empty, or its entry leaves this cycle).
    s1_valid_d = ready_o ? valid_i : s1_valid_q;
    s1_cnt_d   = in_fire ? cnt_i  : s1_cnt_q;
    s1_zero_d  = in_fire ? zero_i : s1_zero_q;

    // S2 reloads only when it may advance; an empty S1 makes it go invalid.
    // Data is left untouched otherwise so a stalled result stays stable.
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    onehot_d   = s1_adv ? dec_onehot : onehot_q;
    mask_d     = s1_adv ? dec_mask   : mask_q;
    err_d      = s1_adv ? dec_err    : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      onehot_q   <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      onehot_q   <= onehot_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
    end
  end

  assign valid_o  = s2_valid_q;
  assign onehot_o = onehot_q;
  assign mask_o   = mask_q;
  assign err_o    = err_q;

  // A stalled result must not change underneath the consumer.
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !ready_i) |=> (valid_o && $stable(onehot_o) && $stable(mask_o) && $stable(err_o)));

  // The one-hot output never carries more than one set bit.
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    valid_o |-> $onehot0(onehot_o));

endmodule
